alu_share_arb: RTL

Two-port arbiter that shares the single 32-bit combinational ALU (opcodes ADD..LUI, 5-bit ALUctr) between two requesters, e.g. the main execute stage and the branch-resolution unit. It registers the winning operand set onto the ALU inputs, captures the ALU outputs one cycle later into a per-requester response buffer, and returns result plus flags over valid/ready handshakes.

---
 rtl/alu_share_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external 32-bit combinational ALU between two
// requesters. Stage S1 registers the winning operand set onto the ALU
// inputs. Stage S2 captures the ALU outputs into a per-requester response
// buffer on the following edge.
// Optional feature: define ALUARB_RR_EN for round-robin tie-breaking.
// When it is undefined, the arbiter uses fixed priority (req0 > req1).
module alu_share_arb #(
    parameter int DW = 32,
    parameter int OW = 5
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [OW-1:0] req0_opr,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req0_cin,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [OW-1:0] req1_opr,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic          req1_cin,

    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_res,
    output logic [3:0]    rsp0_flags,

    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_res,
    output logic [3:0]    rsp1_flags,

    output logic [OW-1:0] alu_opr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_ext,
    input  logic          alu_zf,
    input  logic          alu_of,
    input  logic          alu_br
);

    // Per-requester views so both ports share one generate body
    logic [1:0]    req_valid;
    logic [1:0]    rsp_ready;
    logic [1:0]    busy;
    logic [1:0]    eligible;
    logic [1:0]    grant;
    logic [1:0]    capture;

    // Issue stage (S1)
    logic          s1_valid_reg;
    logic          s1_id_reg;
    logic [OW-1:0] alu_opr_reg;
    logic [DW-1:0] alu_a_reg;
    logic [DW-1:0] alu_b_reg;
    logic          alu_cin_reg;

    // Response buffers (S2)
    logic [1:0]    rsp_valid_reg;
    logic [DW-1:0] rsp_res_reg   [2];
    logic [3:0]    rsp_flags_reg [2];

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // A requester is busy while its op sits in S1 or while its
            // response buffer is full and not being drained this cycle.
            assign capture[gi]  = s1_valid_reg && (s1_id_reg == 1'(gi));
            assign busy[gi]     = capture[gi] || (rsp_valid_reg[gi] && !rsp_ready[gi]);
            assign eligible[gi] = req_valid[gi] && !busy[gi];

            // Response buffer: capture wins over a simultaneous pop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rsp_valid_reg[gi] <= 1'b0;
                    rsp_res_reg[gi]   <= '0;
                    rsp_flags_reg[gi] <= '0;
                end else if (capture[gi]) begin
                    rsp_valid_reg[gi] <= 1'b1;
                    rsp_res_reg[gi]   <= alu_res;
                    rsp_flags_reg[gi] <= {alu_br, alu_of, alu_zf, alu_ext};
                end else if (rsp_valid_reg[gi] && rsp_ready[gi]) begin
                    rsp_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef ALUARB_RR_EN
    // Last-grant pointer: 1 means req1 was granted last, so req0 wins a tie
    logic last_grant_reg;

    // Round-robin grant: on a tie the requester not granted last wins
    always_comb begin
        grant = 2'b00;
        if (eligible[0] && (!eligible[1] || last_grant_reg)) begin
            grant[0] = 1'b1;
        end else if (eligible[1]) begin
            grant[1] = 1'b1;
        end
    end

    // Pointer moves only when something is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (|grant) begin
            last_grant_reg <= grant[1];
        end
    end
`else
    // Fixed priority grant: req0 always beats req1
    always_comb begin
        grant    = 2'b00;
        grant[0] = eligible[0];
        grant[1] = eligible[1] && !eligible[0];
    end
`endif

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Issue register: load the winner's operands, else hold ALU inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= 1'b0;
            alu_opr_reg  <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_cin_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= |grant;
            if (|grant) begin
                s1_id_reg   <= grant[1];
                alu_opr_reg <= grant[1] ? req1_opr : req0_opr;
                alu_a_reg   <= grant[1] ? req1_a   : req0_a;
                alu_b_reg   <= grant[1] ? req1_b   : req0_b;
                alu_cin_reg <= grant[1] ? req1_cin : req0_cin;
            end
        end
    end

    assign alu_opr    = alu_opr_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_cin    = alu_cin_reg;

    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp0_res   = rsp_res_reg[0];
    assign rsp0_flags = rsp_flags_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp1_res   = rsp_res_reg[1];
    assign rsp1_flags = rsp_flags_reg[1];

endmodule
